// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round constants, sequencer encoding, GF(2^8) helpers.
package aes_pkg;

    // Sequencer encoding (ROUND covers rounds 1..10 via a separate counter)
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t SEQ_LOAD  = 2'd0;
    localparam seq_state_t SEQ_ROUND = 2'd1;
    localparam seq_state_t SEQ_DONE  = 2'd2;

    localparam int unsigned NUM_ROUNDS = 10;

    // Rcon[1..10] stored at index 0..9
    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant for round r (1..10); zero outside that range
    function automatic logic [7:0] rcon_for(input logic [3:0] r);
        logic [3:0] idx;
        idx = r - 4'd1;
        if (r >= 4'd1 && r <= 4'd10) begin
            return RCON[idx];
        end
        return 8'h00;
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on a single 32-bit column, row 0 in the top byte
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // MixColumns on the full state; column c occupies bytes 4c..4c+3
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a combinational 256-entry lookup.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes128_encrypt.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly,
// free-running with an 11-cycle period and a one-cycle ready pulse per block.
module aes128_encrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] out,
    output logic         ready
);

    seq_state_t   r_seq;
    logic [3:0]   r_round;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [127:0] r_out;
    logic         r_ready;

    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [31:0]  w_rot;
    logic [31:0]  w_subword;
    logic [31:0]  w_temp;
    logic [127:0] w_rk_next;
    logic [127:0] w_round_out;
    logic         w_last_round;
    logic         w_load;

    // ShiftRows: byte (row r, column c) takes the byte from column (c + r) mod 4
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] res;
        int src;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            src = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
            res[127-8*i -: 8] = s[127-8*src -: 8];
        end
        return res;
    endfunction

    // SubBytes on all 16 state bytes
    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_state_sbox
            aes_sbox u_sbox (
                .i_byte (r_state[127-8*g -: 8]),
                .o_byte (w_sb[127-8*g -: 8])
            );
        end
    endgenerate

    // SubWord(RotWord(w3)) for the key schedule
    assign w_rot = {r_rk[23:0], r_rk[31:24]};

    generate
        for (g = 0; g < 4; g++) begin : g_key_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[31-8*g -: 8]),
                .o_byte (w_subword[31-8*g -: 8])
            );
        end
    endgenerate

    assign w_temp            = w_subword ^ {rcon_for(r_round), 24'h000000};
    assign w_rk_next[127:96] = r_rk[127:96] ^ w_temp;
    assign w_rk_next[95:64]  = r_rk[95:64]  ^ w_rk_next[127:96];
    assign w_rk_next[63:32]  = r_rk[63:32]  ^ w_rk_next[95:64];
    assign w_rk_next[31:0]   = r_rk[31:0]   ^ w_rk_next[63:32];

    assign w_sr         = shift_rows(w_sb);
    assign w_mc         = mix_columns(w_sr);
    assign w_last_round = (r_round == 4'd10);
    assign w_round_out  = (w_last_round ? w_sr : w_mc) ^ w_rk_next;

    // DONE doubles as the load cycle of the next block so the period stays at 11
    assign w_load = (r_seq == SEQ_LOAD) || (r_seq == SEQ_DONE);

    // Sequencer, round counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq   <= SEQ_LOAD;
            r_round <= 4'd0;
            r_out   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_seq)
                SEQ_LOAD, SEQ_DONE: begin
                    r_ready <= 1'b0;
                    r_round <= 4'd1;
                    r_seq   <= SEQ_ROUND;
                end
                SEQ_ROUND: begin
                    if (w_last_round) begin
                        r_out   <= w_round_out;
                        r_ready <= 1'b1;
                        r_seq   <= SEQ_DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_seq   <= SEQ_LOAD;
                end
            endcase
        end
    end

    // Cipher state and round key; contents are don't-care under reset
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_state <= in ^ key;
            r_rk    <= key;
        end else if (r_seq == SEQ_ROUND) begin
            r_state <= w_round_out;
            r_rk    <= w_rk_next;
        end
    end

    assign out   = r_out;
    assign ready = r_ready;

endmodule

// File: tb/tb_aes128_encrypt.sv
// Scoreboard bench for aes128_encrypt using FIPS-197 / SP800-38A known-answer vectors.
module tb_aes128_encrypt;

    logic         clk;
    logic         reset;
    logic [127:0] in;
    logic [127:0] key;
    logic [127:0] out;
    logic         ready;

    aes128_encrypt dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .key   (key),
        .out   (out),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] KEY_A = 128'h0;
    localparam logic [127:0] PT_A  = 128'h0;
    localparam logic [127:0] CT_A  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_C = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_C  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_C  = 128'h3925841d02dc09fbdc118597196a0b32;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulses = 0;
    int cyc = 0;
    int prev_cyc = 0;
    bit have_prev = 1'b0;
    bit rst_seen = 1'b0;
    logic [127:0] last_out = '0;
    logic [127:0] sb_q [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle counter and record of whether reset was sampled on the last edge
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    // Monitor: pop expected ciphertext on each ready, check spacing and hold
    always @(negedge clk) begin
        if (rst_seen) begin
            check("rst_out", out, 128'h0);
            check("rst_ready", {127'h0, ready}, 128'h0);
            last_out  = '0;
            have_prev = 1'b0;
        end else if (ready) begin
            n_pulses++;
            if (sb_q.size() == 0) begin
                check("unexp_ready", {127'h0, ready}, 128'h0);
            end else begin
                check("ciphertext", out, sb_q.pop_front());
            end
            if (have_prev) begin
                check("period", 128'(cyc - prev_cyc), 128'd11);
            end
            prev_cyc  = cyc;
            have_prev = 1'b1;
            last_out  = out;
        end else begin
            check("out_hold", out, last_out);
        end
    end

    initial begin
        reset = 1'b1;
        in    = PT_A;
        key   = KEY_A;
        repeat (3) tick();
        check("reset_out", out, 128'h0);
        check("reset_ready", {127'h0, ready}, 128'h0);

        // Block A: zero key / zero plaintext; switch to B mid-flight
        sb_q.push_back(CT_A);
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check($sformatf("rdy_low_e%0d", e), {127'h0, ready}, 128'h0);
            if (e == 4) begin
                in  = PT_B;
                key = KEY_B;
                sb_q.push_back(CT_B);
            end
        end
        tick();                        // edge 11: A completes
        repeat (4) tick();             // edge 15: B in round 3
        in  = PT_C;
        key = KEY_C;
        sb_q.push_back(CT_C);          // block C
        sb_q.push_back(CT_C);          // block D
        sb_q.push_back(CT_C);          // block E
        repeat (40) tick();            // edge 55: E completes

        // Block F starts at edge 56; abort it during round 5
        repeat (5) tick();             // edge 60
        reset = 1'b1;
        tick();                        // edge 61
        check("abort_out", out, 128'h0);
        check("abort_ready", {127'h0, ready}, 128'h0);
        in  = PT_B;
        key = KEY_B;
        sb_q.push_back(CT_B);
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check($sformatf("rdy_low_r%0d", e), {127'h0, ready}, 128'h0);
        end
        tick();                        // edge 11 after release: B completes

        // Reset coinciding with completion of the following block
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("coinc_out", out, 128'h0);
        check("coinc_ready", {127'h0, ready}, 128'h0);
        reset = 1'b0;
        repeat (2) tick();

        check("sb_empty", 128'(sb_q.size()), 128'd0);
        check("pulse_count", 128'(n_pulses), 128'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
